addr_latch_8: RTL and testbench

ADDR_LATCH_8 -- requirements
Module: addr_latch_8

---
 rtl/addr_latch_8.sv | 103 ++++++++++
 tb/tb_addr_latch_8.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/addr_latch_8.sv
// addr_latch_8: 8-bit addressable latch with auto-address fill pointer.
// Optional readback port Y/Output_bar enabled by ADDR_LATCH_READBACK_EN.
module addr_latch_8 #(
    parameter int DELAY_RISE = 20,
    parameter int DELAY_FALL = 20
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       E_bar,
    input  logic       Clear_bar,
    input  logic       D,
    input  logic [2:0] A,
    input  logic       Auto,
    output logic [7:0] Q,
    output logic [2:0] Ptr,
    output logic       Done
`ifdef ADDR_LATCH_READBACK_EN
    ,
    input  logic       Output_bar,
    output wire        Y
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t     state_r;
    state_t     state_n;
    logic [2:0] ptr_r;
    logic [2:0] ptr_n;
    logic [7:0] q_r;
    logic [7:0] q_n;
    logic       done_r;
    logic       done_n;
    logic [2:0] ea;
    logic       auto_wr;
    logic       clr_mode;

    assign ea       = Auto ? ptr_r : A;
    assign auto_wr  = Auto && !E_bar;
    assign clr_mode = !Clear_bar && E_bar;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= IDLE;
            ptr_r   <= 3'd0;
            q_r     <= 8'h00;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            ptr_r   <= ptr_n;
            q_r     <= q_n;
            done_r  <= done_n;
        end
    end

    always_comb begin
        q_n = q_r;
        unique case ({Clear_bar, E_bar})
            2'b10: q_n[ea] = D;
            2'b11: q_n = q_r;
            2'b00: begin
                q_n     = 8'h00;
                q_n[ea] = D;
            end
            2'b01: q_n = 8'h00;
            default: q_n = q_r;
        endcase
    end

    // Clear mode wins; otherwise only auto-mode writes move the pointer.
    always_comb begin
        state_n = state_r;
        ptr_n   = ptr_r;
        done_n  = 1'b0;
        if (clr_mode) begin
            state_n = IDLE;
            ptr_n   = 3'd0;
        end else if (auto_wr) begin
            ptr_n  = ptr_r + 3'd1;
            done_n = (ptr_r == 3'd7);
            unique case (state_r)
                IDLE: state_n = FILL;
                FILL: begin
                    if (ptr_r == 3'd7)
                        state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign #(DELAY_RISE, DELAY_FALL) Q    = q_r;
    assign #(DELAY_RISE, DELAY_FALL) Done = done_r;
    assign Ptr = ptr_r;

`ifdef ADDR_LATCH_READBACK_EN
    assign #(DELAY_RISE, DELAY_FALL) Y = Output_bar ? 1'bz : q_r[A];
`endif

endmodule

// File: tb/tb_addr_latch_8.sv
// Directed self-checking bench for addr_latch_8.
// Covers readback port when ADDR_LATCH_READBACK_EN is defined.
module tb_addr_latch_8;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       E_bar;
    logic       Clear_bar;
    logic       D;
    logic [2:0] A;
    logic       Auto;
    logic [7:0] Q;
    logic [2:0] Ptr;
    logic       Done;
`ifdef ADDR_LATCH_READBACK_EN
    logic       Output_bar;
    wire        Y;
`endif

    int passed = 0;
    int total  = 0;
    logic [7:0] dpat;

    addr_latch_8 dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .E_bar     (E_bar),
        .Clear_bar (Clear_bar),
        .D         (D),
        .A         (A),
        .Auto      (Auto),
        .Q         (Q),
        .Ptr       (Ptr),
        .Done      (Done)
`ifdef ADDR_LATCH_READBACK_EN
        ,
        .Output_bar(Output_bar),
        .Y         (Y)
`endif
    );

    always #50 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check1(input string tag, input logic obs,
                          input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    initial begin
        Reset = 1'b1;
        E_bar = 1'b0;
        Clear_bar = 1'b1;
        D = 1'b1;
        A = 3'd0;
        Auto = 1'b0;
`ifdef ADDR_LATCH_READBACK_EN
        Output_bar = 1'b1;
`endif
        tick();
        check("rst_q", Q, 8'h00);
        check("rst_ptr", {5'd0, Ptr}, 8'd0);
        check1("rst_done", Done, 1'b0);

        Reset = 1'b0;
        A = 3'd3;
        tick();
        check("wr_a3", Q, 8'h08);
        A = 3'd6;
        tick();
        check("wr_a6", Q, 8'h48);
        E_bar = 1'b1;
        repeat (5) tick();
        check("mem_hold", Q, 8'h48);
        check("mem_ptr", {5'd0, Ptr}, 8'd0);

`ifdef ADDR_LATCH_READBACK_EN
        A = 3'd6;
        Output_bar = 1'b0;
        #30;
        check1("y_a6", Y, 1'b1);
        A = 3'd5;
        #30;
        check1("y_a5", Y, 1'b0);
        Output_bar = 1'b1;
        #30;
        check1("y_z", Y, 1'bz);
        tick();
`endif

        E_bar = 1'b0;
        D = 1'b1;
        for (int i = 0; i < 8; i++) begin
            A = 3'(i);
            tick();
        end
        check("fill_ff", Q, 8'hFF);
        Clear_bar = 1'b0;
        A = 3'd2;
        tick();
        check("demux", Q, 8'h04);
        E_bar = 1'b1;
        tick();
        check("clear_q", Q, 8'h00);
        check("clear_ptr", {5'd0, Ptr}, 8'd0);

        Clear_bar = 1'b1;
        Auto = 1'b1;
        E_bar = 1'b0;
        dpat = 8'b0100_1101;
        for (int i = 0; i < 8; i++) begin
            D = dpat[i];
            tick();
            if (i == 0) begin
                check("auto_ptr1", {5'd0, Ptr}, 8'd1);
                check1("auto_done0", Done, 1'b0);
            end
            if (i == 6) begin
                check("auto_ptr7", {5'd0, Ptr}, 8'd7);
                check1("auto_done6", Done, 1'b0);
            end
        end
        check("auto_q", Q, 8'h4D);
        check("auto_ptr0", {5'd0, Ptr}, 8'd0);
        check1("auto_done", Done, 1'b1);
        E_bar = 1'b1;
        tick();
        check1("done_pulse", Done, 1'b0);
        check("auto_hold", Q, 8'h4D);

        Clear_bar = 1'b0;
        tick();
        check("clr2", Q, 8'h00);
        Clear_bar = 1'b1;
        E_bar = 1'b0;
        D = 1'b1;
        repeat (3) tick();
        check("pause_q", Q, 8'h07);
        check("pause_ptr", {5'd0, Ptr}, 8'd3);
        Auto = 1'b0;
        A = 3'd7;
        repeat (4) tick();
        check("paused_q", Q, 8'h87);
        check("paused_ptr", {5'd0, Ptr}, 8'd3);
        check1("paused_done", Done, 1'b0);
        Auto = 1'b1;
        D = 1'b0;
        repeat (4) tick();
        check("resume_ptr7", {5'd0, Ptr}, 8'd7);
        check1("resume_done0", Done, 1'b0);
        tick();
        check("resume_q", Q, 8'h07);
        check("resume_ptr0", {5'd0, Ptr}, 8'd0);
        check1("resume_done", Done, 1'b1);

        D = 1'b1;
        repeat (2) tick();
        check("pre_clr_ptr", {5'd0, Ptr}, 8'd2);
        Clear_bar = 1'b0;
        E_bar = 1'b1;
        tick();
        check("clr_prio_ptr", {5'd0, Ptr}, 8'd0);
        Clear_bar = 1'b1;
        E_bar = 1'b0;
        repeat (2) tick();
        Reset = 1'b1;
        tick();
        check("rst2_q", Q, 8'h00);
        check("rst2_ptr", {5'd0, Ptr}, 8'd0);
        check1("rst2_done", Done, 1'b0);
        Reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i < 7)
                check1("refill_nodone", Done, 1'b0);
        end
        check("refill_q", Q, 8'hFF);
        check1("refill_done", Done, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
